// File: rtl/decode_stage.sv
// RV32I decode stage: decodes OP / OP-IMM from IF/ID, reads the 32-entry register file
// with write-through bypass, and keeps a sticky illegal-instruction flag.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_i,
    input  logic            instr_valid_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            Regwritte_ctrl,
    output logic [XLEN-1:0] Data1_reg,
    output logic [XLEN-1:0] Data2_reg,
    output logic [4:0]      Rd_IF_ID,
    output logic [3:0]      ALuctrl,
    output logic            illegal_o
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    logic [6:0]      opcode_s;
    logic [4:0]      rd_s;
    logic [2:0]      funct3_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_s;
    logic            is_op_s;
    logic            is_opimm_s;
    logic            f7_ok_s;
    logic [3:0]      alu_s;
    logic            legal_s;
    logic            wb_wr_s;
    logic [XLEN-1:0] rs1_val_s;
    logic [XLEN-1:0] rs2_val_s;
    logic            illegal_d;
    logic            illegal_q;
    logic [XLEN-1:0] regs_q [1:NREG-1];

    assign opcode_s   = instr_i[6:0];
    assign rd_s       = instr_i[11:7];
    assign funct3_s   = instr_i[14:12];
    assign rs1_s      = instr_i[19:15];
    assign rs2_s      = instr_i[24:20];
    assign funct7_s   = instr_i[31:25];
    assign imm_s      = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign is_op_s    = (opcode_s == OPC_OP);
    assign is_opimm_s = (opcode_s == OPC_OPIMM);

    // A writeback coinciding with reset is dropped, both for storage and for the bypass.
    assign wb_wr_s = wb_we_i & (wb_rd_i != 5'd0) & ~rst;

    // ALU operation select and funct7 legality for OP / OP-IMM.
    always_comb begin
        alu_s   = ALU_ADD;
        f7_ok_s = 1'b0;
        case (funct3_s)
            3'b000: begin
                if (is_op_s && (funct7_s == F7_ALT)) begin
                    alu_s   = ALU_SUB;
                    f7_ok_s = 1'b1;
                end else begin
                    alu_s   = ALU_ADD;
                    f7_ok_s = is_opimm_s | (funct7_s == F7_ZERO);
                end
            end
            3'b001: begin
                alu_s   = ALU_SLL;
                f7_ok_s = (funct7_s == F7_ZERO);
            end
            3'b010: begin
                alu_s   = ALU_SLT;
                f7_ok_s = is_opimm_s | (funct7_s == F7_ZERO);
            end
            3'b011: begin
                alu_s   = ALU_SLTU;
                f7_ok_s = is_opimm_s | (funct7_s == F7_ZERO);
            end
            3'b100: begin
                alu_s   = ALU_XOR;
                f7_ok_s = is_opimm_s | (funct7_s == F7_ZERO);
            end
            3'b101: begin
                if (funct7_s == F7_ZERO) begin
                    alu_s   = ALU_SRL;
                    f7_ok_s = 1'b1;
                end else if (funct7_s == F7_ALT) begin
                    alu_s   = ALU_SRA;
                    f7_ok_s = 1'b1;
                end else begin
                    alu_s   = ALU_SRL;
                    f7_ok_s = 1'b0;
                end
            end
            3'b110: begin
                alu_s   = ALU_OR;
                f7_ok_s = is_opimm_s | (funct7_s == F7_ZERO);
            end
            3'b111: begin
                alu_s   = ALU_AND;
                f7_ok_s = is_opimm_s | (funct7_s == F7_ZERO);
            end
            default: begin
                alu_s   = ALU_ADD;
                f7_ok_s = 1'b0;
            end
        endcase
    end

    assign legal_s   = instr_valid_i & (is_op_s | is_opimm_s) & f7_ok_s;
    assign illegal_d = illegal_q | (instr_valid_i & ~legal_s);

    // Read port A with x0 forced to zero and same-cycle writeback forwarding.
    always_comb begin
        rs1_val_s = '0;
        if (rs1_s == 5'd0) begin
            rs1_val_s = '0;
        end else if (wb_wr_s && (wb_rd_i == rs1_s)) begin
            rs1_val_s = wb_data_i;
        end else begin
            rs1_val_s = regs_q[rs1_s];
        end
    end

    // Read port B, same rules as port A.
    always_comb begin
        rs2_val_s = '0;
        if (rs2_s == 5'd0) begin
            rs2_val_s = '0;
        end else if (wb_wr_s && (wb_rd_i == rs2_s)) begin
            rs2_val_s = wb_data_i;
        end else begin
            rs2_val_s = regs_q[rs2_s];
        end
    end

    // ID/EX control and operands; anything not legal becomes an all-zero bubble.
    always_comb begin
        Regwritte_ctrl = 1'b0;
        Data1_reg      = '0;
        Data2_reg      = '0;
        Rd_IF_ID       = 5'd0;
        ALuctrl        = ALU_ADD;
        if (legal_s) begin
            Regwritte_ctrl = (rd_s != 5'd0);
            Data1_reg      = rs1_val_s;
            Data2_reg      = is_op_s ? rs2_val_s : imm_s;
            Rd_IF_ID       = rd_s;
            ALuctrl        = alu_s;
        end else begin
            Regwritte_ctrl = 1'b0;
            Data1_reg      = '0;
            Data2_reg      = '0;
            Rd_IF_ID       = 5'd0;
            ALuctrl        = ALU_ADD;
        end
    end

    // Register file write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_wr_s) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    // Sticky illegal-instruction flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the combinational outputs.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        Regwritte_ctrl;
    logic [31:0] Data1_reg;
    logic [31:0] Data2_reg;
    logic [4:0]  Rd_IF_ID;
    logic [3:0]  ALuctrl;
    logic        illegal_o;

    decode_stage #(.XLEN(32), .NREG(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_i        (instr_i),
        .instr_valid_i  (instr_valid_i),
        .wb_we_i        (wb_we_i),
        .wb_rd_i        (wb_rd_i),
        .wb_data_i      (wb_data_i),
        .Regwritte_ctrl (Regwritte_ctrl),
        .Data1_reg      (Data1_reg),
        .Data2_reg      (Data2_reg),
        .Rd_IF_ID       (Rd_IF_ID),
        .ALuctrl        (ALuctrl),
        .illegal_o      (illegal_o)
    );

    typedef struct {
        int          id;
        logic        rw;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t stim_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input int id, input string f, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL R%0d %s got=%h want=%h", id, f, got, want);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cmp(mon_e.id, "regwrite", {31'd0, Regwritte_ctrl}, {31'd0, mon_e.rw});
            cmp(mon_e.id, "data1",    Data1_reg,               mon_e.d1);
            cmp(mon_e.id, "data2",    Data2_reg,               mon_e.d2);
            cmp(mon_e.id, "rd",       {27'd0, Rd_IF_ID},       {27'd0, mon_e.rd});
            cmp(mon_e.id, "aluctrl",  {28'd0, ALuctrl},        {28'd0, mon_e.alu});
            cmp(mon_e.id, "illegal",  {31'd0, illegal_o},      {31'd0, mon_e.ill});
        end
    end

    task automatic step(input int id, input logic r, input logic v, input logic [31:0] ins,
                        input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic e_rw, input logic [31:0] e_d1, input logic [31:0] e_d2,
                        input logic [4:0] e_rd, input logic [3:0] e_alu, input logic e_ill);
        @(posedge clk);
        #1;
        rst           = r;
        instr_valid_i = v;
        instr_i       = ins;
        wb_we_i       = we;
        wb_rd_i       = wrd;
        wb_data_i     = wd;
        stim_e.id  = id;
        stim_e.rw  = e_rw;
        stim_e.d1  = e_d1;
        stim_e.d2  = e_d2;
        stim_e.rd  = e_rd;
        stim_e.alu = e_alu;
        stim_e.ill = e_ill;
        exp_q.push_back(stim_e);
    endtask

    initial begin
        rst           = 1'b1;
        instr_i       = 32'd0;
        instr_valid_i = 1'b0;
        wb_we_i       = 1'b0;
        wb_rd_i       = 5'd0;
        wb_data_i     = 32'd0;
        repeat (2) @(posedge clk);
        //     id  rst   vld   instr          we    wrd    wdata          rw    d1             d2             rd     alu    ill
        step(1,  1'b0, 1'b0, 32'h0000_0000, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(2,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 5'd5,  32'd7,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(3,  1'b0, 1'b0, 32'h0000_0000, 1'b1, 5'd6,  32'd3,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(4,  1'b0, 1'b1, 32'h0062_83B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'd7,         32'd3,         5'd7,  4'd0,  1'b0);
        step(5,  1'b0, 1'b1, 32'h4062_83B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'd7,         32'd3,         5'd7,  4'd1,  1'b0);
        step(6,  1'b0, 1'b1, 32'hFFF0_0093, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0,         32'hFFFF_FFFF, 5'd1,  4'd0,  1'b0);
        step(7,  1'b0, 1'b1, 32'h4030_D113, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0,         32'h0000_0403, 5'd2,  4'd7,  1'b0);
        step(8,  1'b0, 1'b1, 32'h0052_83B3, 1'b1, 5'd5,  32'h1234_5678, 1'b1, 32'h1234_5678, 32'h1234_5678, 5'd7,  4'd0,  1'b0);
        step(9,  1'b0, 1'b1, 32'h0062_83B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1234_5678, 32'd3,         5'd7,  4'd0,  1'b0);
        step(10, 1'b0, 1'b1, 32'h0042_9193, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1234_5678, 32'd4,         5'd3,  4'd2,  1'b0);
        step(11, 1'b0, 1'b1, 32'h0062_B233, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1234_5678, 32'd3,         5'd4,  4'd4,  1'b0);
        step(12, 1'b0, 1'b1, 32'h0062_D3B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1234_5678, 32'd3,         5'd7,  4'd6,  1'b0);
        step(13, 1'b0, 1'b1, 32'h0062_E3B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1234_5678, 32'd3,         5'd7,  4'd8,  1'b0);
        step(14, 1'b0, 1'b1, 32'h0062_F3B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1234_5678, 32'd3,         5'd7,  4'd9,  1'b0);
        step(15, 1'b0, 1'b1, 32'h0000_00B3, 1'b1, 5'd0,  32'h0000_DEAD, 1'b1, 32'h0,         32'h0,         5'd1,  4'd0,  1'b0);
        step(16, 1'b0, 1'b1, 32'h0000_00B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0,         32'h0,         5'd1,  4'd0,  1'b0);
        step(17, 1'b0, 1'b1, 32'h0010_8033, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(18, 1'b0, 1'b0, 32'h4042_9193, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(19, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(20, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(21, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(22, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b1);
        step(23, 1'b0, 1'b1, 32'h0062_83B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'h1234_5678, 32'd3,         5'd7,  4'd0,  1'b1);
        step(24, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 5'd5,  32'd7,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b1);
        step(25, 1'b0, 1'b1, 32'h0052_83B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'd7,         32'd7,         5'd7,  4'd0,  1'b1);
        step(26, 1'b1, 1'b1, 32'h0052_83B3, 1'b1, 5'd5,  32'h0000_0099, 1'b1, 32'h0,         32'h0,         5'd7,  4'd0,  1'b0);
        step(27, 1'b0, 1'b1, 32'h0052_83B3, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0,         32'h0,         5'd7,  4'd0,  1'b0);
        step(28, 1'b0, 1'b1, 32'h0262_83B3, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b0);
        step(29, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b1);
        step(30, 1'b0, 1'b1, 32'h4042_9193, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         32'h0,         5'd0,  4'd0,  1'b1);
        @(posedge clk);
        #1;
        instr_valid_i = 1'b0;
        wb_we_i       = 1'b0;
        @(negedge clk);
        #1;
        cmp(0, "queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
